y86_alu: RTL and testbench

- 64-bit integer ALU for the Y86-64 execute stage. Performs the four OPq operations: addq, subq, andq, xorq.
- Produces a result and the condition-code triple [ZF, SF, OF].
- Result and flags are registered, giving one-cycle latency. The execute stage consumes them and latches CC for the cmovXX and jXX condition logic.

---
 rtl/y86_alu.sv | 94 +++++++++
 tb/tb_y86_alu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/y86_alu.sv
// -----------------------------------------------------------------------------
// y86_alu
//   Integer ALU for the Y86-64 execute stage. Implements the four OPq
//   operations (addq, subq, andq, xorq) and produces a result plus the
//   condition-code triple [ZF, SF, OF]. Result and flags are registered,
//   giving exactly one cycle of latency with one new operation per cycle.
//
// Ports:
//   clk      in   1      system clock, all state updates on the rising edge
//   rst      in   1      synchronous active-high reset (priority over en)
//   en       in   1      capture enable; registers result and flags this edge
//   a        in   WIDTH  first operand (execute drives valB here)
//   b        in   WIDTH  second operand (execute drives valA here)
//   op       in   2      00 add, 01 sub (a - b), 10 and, 11 xor
//   out      out  WIDTH  registered result
//   conCode  out  3      registered flags: [2]=ZF, [1]=SF, [0]=OF
// -----------------------------------------------------------------------------
module y86_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       conCode
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  localparam int MSB = WIDTH - 1;

  alu_op_e          op_sel;
  logic [WIDTH-1:0] r;
  logic             zf;
  logic             sf;
  logic             of;

  assign op_sel = alu_op_e'(op);

  // Combinational datapath. Arithmetic wraps modulo 2^WIDTH; the carry out
  // is intentionally dropped because Y86 has no carry flag.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    r  = '0;
    of = 1'b0;
    unique case (op_sel)
      OP_ADD: begin
        r  = a + b;
        // Signed overflow: operands agree in sign but the result does not.
        of = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // subq computes valB - valA, which is a - b on this port mapping.
        r  = a - b;
        // Signed overflow: operands differ in sign and the result's sign
        // differs from the minuend.
        of = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      default: begin
        r  = '0;
        of = 1'b0;
      end
    endcase
  end

  assign zf = (r == '0);
  assign sf = r[MSB];

  // Result/flag register. Reset wins over en, so a capture requested on the
  // same edge as reset is discarded.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      out     <= '0;
      conCode <= 3'b000;
    end else if (en) begin
      out     <= r;
      conCode <= {zf, sf, of};
    end
  end

endmodule

// File: tb/tb_y86_alu.sv
// -----------------------------------------------------------------------------
// tb_y86_alu
//   Scoreboard bench for y86_alu. The stimulus process drives one directed
//   vector per cycle (on the falling edge) and pushes the hand-computed
//   register contents expected after the next rising edge. The monitor
//   samples out/conCode 1 time unit after each rising edge and compares them
//   against the head of the queue.
// -----------------------------------------------------------------------------
module tb_y86_alu;

  logic        clk;
  logic        rst;
  logic        en;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic [63:0] out;
  logic [2:0]  conCode;

  logic [63:0] exp_out_q[$];
  logic [2:0]  exp_cc_q[$];
  string       name_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL_ONE = 64'hFFFF_FFFF_FFFF_FFFF;

  y86_alu #(.WIDTH(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a       (a),
    .b       (b),
    .op      (op),
    .out     (out),
    .conCode (conCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got_out,
                       input logic [2:0] got_cc, input logic [63:0] exp_out,
                       input logic [2:0] exp_cc);
    n_cmp++;
    if (got_out !== exp_out || got_cc !== exp_cc) begin
      n_fail++;
      $display("FAIL %s: got out=%h cc=%b, expected out=%h cc=%b",
               nm, got_out, got_cc, exp_out, exp_cc);
    end
  endtask

  // Drive one vector before the next rising edge and record what the
  // registers must hold after that edge.
  task automatic issue(input logic r, input logic e, input logic [63:0] av,
                       input logic [63:0] bv, input logic [1:0] o,
                       input logic [63:0] eo, input logic [2:0] ec,
                       input string nm);
    @(negedge clk);
    rst = r;
    en  = e;
    a   = av;
    b   = bv;
    op  = o;
    exp_out_q.push_back(eo);
    exp_cc_q.push_back(ec);
    name_q.push_back(nm);
  endtask

  // Monitor: every rising edge presents a new register state.
  always @(posedge clk) begin
    #1;
    if (exp_out_q.size() > 0) begin
      check(name_q.pop_front(), out, conCode,
            exp_out_q.pop_front(), exp_cc_q.pop_front());
    end
  end

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    op  = 2'b00;

    //     rst   en    a                  b                  op     out                     cc      name
    issue(1'b1, 1'b1, 64'd123,           64'd456,           2'b00, 64'd0,                  3'b000, "reset");
    issue(1'b0, 1'b0, 64'd5,             64'd7,             2'b00, 64'd0,                  3'b000, "hold_after_reset");
    issue(1'b0, 1'b1, 64'd5,             64'd7,             2'b00, 64'd12,                 3'b000, "add_5_7");
    issue(1'b0, 1'b1, MAX_POS,           64'd1,             2'b00, MIN_NEG,                3'b011, "add_pos_overflow");
    issue(1'b0, 1'b1, ALL_ONE,           64'd1,             2'b00, 64'd0,                  3'b100, "add_carry_wrap");
    issue(1'b0, 1'b1, MIN_NEG,           MIN_NEG,           2'b00, 64'd0,                  3'b101, "add_neg_overflow");
    issue(1'b0, 1'b1, 64'd3,             64'd10,            2'b01, 64'hFFFF_FFFF_FFFF_FFF9, 3'b010, "sub_3_10");
    issue(1'b0, 1'b1, 64'd9,             64'd9,             2'b01, 64'd0,                  3'b100, "sub_9_9");
    issue(1'b0, 1'b1, MIN_NEG,           64'd1,             2'b01, MAX_POS,                3'b001, "sub_neg_overflow");
    issue(1'b0, 1'b1, MAX_POS,           ALL_ONE,           2'b01, MIN_NEG,                3'b011, "sub_pos_overflow");
    issue(1'b0, 1'b1, 64'hF0F0,          64'h0FF0,          2'b10, 64'h00F0,               3'b000, "and_basic");
    issue(1'b0, 1'b1, 64'hF0F0,          64'h0FF0,          2'b11, 64'hFF00,               3'b000, "xor_basic");
    issue(1'b0, 1'b1, MIN_NEG,           MIN_NEG,           2'b11, 64'd0,                  3'b100, "xor_of_forced_0");
    issue(1'b0, 1'b1, MIN_NEG,           MAX_POS,           2'b10, 64'd0,                  3'b100, "and_of_forced_0");
    issue(1'b0, 1'b1, ALL_ONE,           MIN_NEG,           2'b10, MIN_NEG,                3'b010, "and_sign");
    issue(1'b0, 1'b1, 64'd1,             64'd1,             2'b00, 64'd2,                  3'b000, "b2b_add");
    issue(1'b0, 1'b1, 64'd1,             64'd1,             2'b01, 64'd0,                  3'b100, "b2b_sub");
    issue(1'b0, 1'b0, 64'd1234,          64'd5,             2'b00, 64'd0,                  3'b100, "hold_en0_a");
    issue(1'b0, 1'b0, ALL_ONE,           ALL_ONE,           2'b01, 64'd0,                  3'b100, "hold_en0_b");
    issue(1'b0, 1'b1, 64'd1,             64'd1,             2'b00, 64'd2,                  3'b000, "pre_reset_load");
    issue(1'b1, 1'b1, 64'd1,             64'd1,             2'b00, 64'd0,                  3'b000, "reset_priority");
    issue(1'b0, 1'b0, 64'd1,             64'd1,             2'b00, 64'd0,                  3'b000, "hold_after_reset2");

    // Bounded drain: give the monitor a few edges to consume the queue.
    for (int i = 0; i < 10 && exp_out_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_out_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected responses never compared, required 0",
               exp_out_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
